// File: rtl/noc_pkg.sv
// noc_pkg: shared flit, port and address definitions for the mesh NoC
package noc_pkg;
    localparam int FLIT_W         = 10;
    localparam int X_ADDR_W       = 4;
    localparam int Y_ADDR_W       = 4;
    localparam int X_NODE_NUM_DEF = 4;
    localparam int Y_NODE_NUM_DEF = 4;
    typedef enum logic [1:0] {FT_BODY = 2'b00, FT_TAIL = 2'b01, FT_HDR = 2'b10} flit_type_e;
    typedef enum logic [2:0] {PORT_L = 3'd1, PORT_E = 3'd2, PORT_N = 3'd3, PORT_W = 3'd4, PORT_S = 3'd5} port_e;
    function automatic logic [FLIT_W-1:0] pack_hdr(input logic [X_ADDR_W-1:0] x, input logic [Y_ADDR_W-1:0] y);
        return {FT_HDR, y, x};
    endfunction
endpackage

// File: rtl/noc_ni_packetizer_if.sv
// noc_ni_packetizer_if: request, payload and flit handshakes of the NI transmitter
interface noc_ni_packetizer_if;
    import noc_pkg::*;
    logic                pkt_valid;
    logic                pkt_ready;
    logic [X_ADDR_W-1:0] pkt_dest_x;
    logic [Y_ADDR_W-1:0] pkt_dest_y;
    logic [3:0]          pkt_len;
    logic                pl_valid;
    logic                pl_ready;
    logic [7:0]          pl_data;
    logic                flit_valid;
    logic                flit_ready;
    logic [FLIT_W-1:0]   flit_out;
    modport slave (
        input  pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len, pl_valid, pl_data, flit_ready,
        output pkt_ready, pl_ready, flit_valid, flit_out
    );
    modport master (
        output pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len, pl_valid, pl_data, flit_ready,
        input  pkt_ready, pl_ready, flit_valid, flit_out
    );
endinterface

// File: rtl/noc_flit_outreg.sv
// noc_flit_outreg: single-stage valid/ready flit register, reusable on router outputs
module noc_flit_outreg
    import noc_pkg::*;
#(
    parameter int W = FLIT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         free
);
    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    assign free  = !valid_q || ready;
    assign valid = valid_q;
    assign dout  = data_q;

    // hold the flit until taken; a load in the handshake cycle overwrites it
    always_comb begin
        valid_d = load || (valid_q && !ready);
        data_d  = load ? din : data_q;
    end

    // register stage, cleared on reset so nothing in flight survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/noc_ni_packetizer.sv
// noc_ni_packetizer: turns a request plus payload stream into header/body/tail flits
module noc_ni_packetizer
    import noc_pkg::*;
#(
    parameter int X_NODE_NUM = X_NODE_NUM_DEF,
    parameter int Y_NODE_NUM = Y_NODE_NUM_DEF,
    parameter int X_S_ADDR   = 0,
    parameter int Y_S_ADDR   = 1,
    parameter int DATA_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    noc_ni_packetizer_if.slave  ni,
    output logic                err_dest,
    output logic                busy,
    output logic [15:0]         pkt_sent
);
    typedef enum logic {S_IDLE, S_BODY} state_e;

    localparam logic [4:0] XN = 5'(X_NODE_NUM);
    localparam logic [4:0] YN = 5'(Y_NODE_NUM);
    localparam bit SELF_OK = (X_S_ADDR < X_NODE_NUM) && (Y_S_ADDR < Y_NODE_NUM);

    state_e            state_d, state_q;
    logic [3:0]        rem_d, rem_q;
    logic              err_d, err_q;
    logic              busy_d, busy_q;
    logic [15:0]       sent_d, sent_q;
    logic              reg_free, legal, pkt_acc, pl_acc, load, tail_hs;
    logic [FLIT_W-1:0] load_flit;

    assign ni.pkt_ready = (state_q == S_IDLE) && reg_free;
    assign ni.pl_ready  = (state_q == S_BODY) && reg_free;
    assign pkt_acc      = ni.pkt_valid && ni.pkt_ready;
    assign pl_acc       = ni.pl_valid && ni.pl_ready;
    assign legal        = ({1'b0, ni.pkt_dest_x} < XN) && ({1'b0, ni.pkt_dest_y} < YN) && (ni.pkt_len != 4'd0) && SELF_OK;
    assign load         = (pkt_acc && legal) || pl_acc;
    assign load_flit    = pl_acc ? {(rem_q > 4'd1) ? FT_BODY : FT_TAIL, ni.pl_data[DATA_W-1:0]}
                                 : pack_hdr(ni.pkt_dest_x, ni.pkt_dest_y);
    assign tail_hs      = ni.flit_valid && ni.flit_ready && (ni.flit_out[FLIT_W-1 -: 2] == FT_TAIL);
    assign err_dest     = err_q;
    assign busy         = busy_q;
    assign pkt_sent     = sent_q;

    noc_flit_outreg #(.W(FLIT_W)) u_outreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .din   (load_flit),
        .ready (ni.flit_ready),
        .valid (ni.flit_valid),
        .dout  (ni.flit_out),
        .free  (reg_free)
    );

    // next state: a legal request opens a packet, the last payload word closes it
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        err_d   = pkt_acc && !legal;
        sent_d  = sent_q + 16'(tail_hs);
        if (pkt_acc && legal) begin
            state_d = S_BODY;
            rem_d   = ni.pkt_len;
        end
        if (pl_acc) begin
            state_d = (rem_q > 4'd1) ? S_BODY : S_IDLE;
            rem_d   = rem_q - 4'd1;
        end
        busy_d = state_d == S_BODY;
    end

    // FSM and counters; reset abandons any partial packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= 4'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            sent_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
        end
    end
endmodule

// File: tb/tb_noc_ni_packetizer.sv
// tb_noc_ni_packetizer: table, hand-written and random packets against a transaction-level model
module tb_noc_ni_packetizer;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_dest, busy;
    logic [15:0] pkt_sent;

    noc_ni_packetizer_if ni();

    noc_ni_packetizer #(
        .X_NODE_NUM (4),
        .Y_NODE_NUM (4),
        .X_S_ADDR   (0),
        .Y_S_ADDR   (1),
        .DATA_W     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ni       (ni),
        .err_dest (err_dest),
        .busy     (busy),
        .pkt_sent (pkt_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] len;
        bit         err;
    } vec_t;

    int          n_chk = 0, n_pass = 0;
    int          cyc = 0;
    logic [9:0]  exp_q[$];
    int          hs_cyc[$];
    int          m_rem = 0;
    logic [15:0] m_sent = 16'd0;
    int          m_err = 0, err_seen = 0;
    int          ready_mode = 0, rdy_idx = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [9:0]  prev_f = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // flit_ready: always-on, the 1,0,0,1 pattern, or random
    initial begin
        ni.flit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ni.flit_ready = (ready_mode == 0) ? 1'b1 :
                            (ready_mode == 1) ? ((rdy_idx % 4 == 0) || (rdy_idx % 4 == 3)) :
                            ($urandom_range(0, 3) != 0);
            rdy_idx++;
        end
    end

    // monitor: every handed-off flit must be the next one the model expects
    always @(negedge clk) begin
        if (!rst_n) prev_v = 1'b0;
        else begin
            if (prev_v && !prev_r) begin
                chk("stall_hold_valid", ni.flit_valid, 1);
                chk("stall_hold_data", ni.flit_out, prev_f);
            end
            if (ni.flit_valid && !ni.flit_ready) chk("pl_ready_in_stall", ni.pl_ready, 0);
            if (err_dest) err_seen++;
            if (ni.flit_valid && ni.flit_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_flit: got 0x%0h, want none", ni.flit_out);
                end else chk("flit", ni.flit_out, exp_q.pop_front());
            end
            prev_v = ni.flit_valid;
            prev_r = ni.flit_ready;
            prev_f = ni.flit_out;
        end
    end

    task automatic req(input logic [3:0] x, input logic [3:0] y, input logic [3:0] len, input bit exp_err);
        bit ok = 1'b0;
        ni.pkt_dest_x = x;
        ni.pkt_dest_y = y;
        ni.pkt_len    = len;
        ni.pkt_valid  = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = ni.pkt_ready;
            @(posedge clk);
            #1;
        end
        ni.pkt_valid = 1'b0;
        if (!ok) begin
            chk("req_timeout", 0, 1);
            return;
        end
        if (exp_err) m_err++;
        else begin
            exp_q.push_back({2'b10, y, x});
            m_rem = len;
        end
        chk("err_dest", err_dest, exp_err);
        chk("busy", busy, !exp_err);
        if (!exp_err) chk("hdr_latency", {ni.flit_valid, ni.flit_out}, {1'b1, 2'b10, y, x});
    endtask

    task automatic word(input logic [7:0] d);
        bit ok = 1'b0;
        ni.pl_data  = d;
        ni.pl_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = ni.pl_ready;
            @(posedge clk);
            #1;
        end
        ni.pl_valid = 1'b0;
        if (!ok) begin
            chk("word_timeout", 0, 1);
            return;
        end
        exp_q.push_back({(m_rem > 1) ? 2'b00 : 2'b01, d});
        if (m_rem == 1) m_sent++;
        m_rem--;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("pkt_sent", pkt_sent, m_sent);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   base;
        tbl[0] = '{4'd4,  4'd0,  4'd1,  1'b1};
        tbl[1] = '{4'd0,  4'd4,  4'd2,  1'b1};
        tbl[2] = '{4'd1,  4'd1,  4'd0,  1'b1};
        tbl[3] = '{4'd0,  4'd1,  4'd2,  1'b0};
        tbl[4] = '{4'd3,  4'd3,  4'd15, 1'b0};
        tbl[5] = '{4'd15, 4'd15, 4'd5,  1'b1};
        tbl[6] = '{4'd0,  4'd0,  4'd1,  1'b0};
        tbl[7] = '{4'd3,  4'd0,  4'd4,  1'b0};
        ni.pkt_valid = 1'b0; ni.pkt_dest_x = '0; ni.pkt_dest_y = '0; ni.pkt_len = '0;
        ni.pl_valid = 1'b0; ni.pl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flit_valid", ni.flit_valid, 0);
        chk("rst_flit_out", ni.flit_out, 0);
        chk("rst_err", err_dest, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_sent", pkt_sent, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // payload in IDLE is ignored
        ni.pl_valid = 1'b1; ni.pl_data = 8'h77;
        @(negedge clk);
        chk("pl_ready_idle", ni.pl_ready, 0);
        @(posedge clk);
        #1;
        ni.pl_valid = 1'b0;

        // basic packet, four flits on consecutive cycles
        base = hs_cyc.size();
        req(4'd2, 4'd3, 4'd3, 1'b0);
        word(8'hA1); word(8'hA2); word(8'hA3);
        drain();
        chk("t1_count", hs_cyc.size() - base, 4);
        if (hs_cyc.size() - base == 4) chk("t1_no_gap", hs_cyc[base+3] - hs_cyc[base], 3);

        // illegal x: accepted, one-cycle err pulse, nothing emitted
        ni.pkt_dest_x = 4'd4; ni.pkt_dest_y = 4'd0; ni.pkt_len = 4'd2; ni.pkt_valid = 1'b1;
        @(negedge clk);
        chk("bad_pkt_ready", ni.pkt_ready, 1);
        @(posedge clk);
        #1;
        ni.pkt_valid = 1'b0;
        m_err++;
        chk("bad_err_pulse", err_dest, 1);
        chk("bad_no_flit", ni.flit_valid, 0);
        chk("bad_pl_ready", ni.pl_ready, 0);
        chk("bad_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("bad_err_one_cycle", err_dest, 0);

        // stalled packet; a request during BODY must be ignored
        ready_mode = 1; rdy_idx = 0;
        req(4'd2, 4'd3, 4'd3, 1'b0);
        ni.pkt_dest_x = 4'd1; ni.pkt_dest_y = 4'd1; ni.pkt_len = 4'd1; ni.pkt_valid = 1'b1;
        @(negedge clk);
        chk("pkt_ready_body", ni.pkt_ready, 0);
        @(posedge clk);
        #1;
        ni.pkt_valid = 1'b0;
        word(8'hA1); word(8'hA2); word(8'hA3);
        drain();
        ready_mode = 0;

        // back-to-back packets with no idle flit between them
        base = hs_cyc.size();
        req(4'd1, 4'd0, 4'd1, 1'b0);
        word(8'h5C);
        req(4'd0, 4'd1, 4'd2, 1'b0);
        word(8'h3D); word(8'h4E);
        drain();
        chk("b2b_count", hs_cyc.size() - base, 5);
        if (hs_cyc.size() - base == 5) chk("b2b_no_gap", hs_cyc[base+4] - hs_cyc[base], 4);

        // table of requests, including the rejected ones
        foreach (tbl[i]) begin
            req(tbl[i].x, tbl[i].y, tbl[i].len, tbl[i].err);
            if (!tbl[i].err) for (int j = 0; j < int'(tbl[i].len); j++) word(8'($urandom));
            drain();
        end

        // asynchronous reset in the middle of a packet
        req(4'd1, 4'd2, 4'd4, 1'b0);
        word(8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flit_valid", ni.flit_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pkt_sent", pkt_sent, 0);
        exp_q.delete();
        m_rem = 0;
        m_sent = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req(4'd3, 4'd3, 4'd1, 1'b0);
        word(8'h99);
        drain();

        // pkt_sent wrap
        force dut.sent_q = 16'hFFFF;
        #1;
        release dut.sent_q;
        m_sent = 16'hFFFF;
        chk("wrap_pre", pkt_sent, 16'hFFFF);
        @(posedge clk);
        #1;
        req(4'd0, 4'd0, 4'd1, 1'b0);
        word(8'h42);
        drain();
        chk("wrap_zero", pkt_sent, 0);

        // random packets, random idle gaps and random flit_ready
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            logic [3:0] x, y, len;
            bit         bad;
            x   = 4'($urandom_range(0, 5));
            y   = 4'($urandom_range(0, 5));
            len = 4'($urandom_range(0, 15));
            bad = !((x < 4) && (y < 4) && (len != 0));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            req(x, y, len, bad);
            if (!bad) for (int j = 0; j < int'(len); j++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                word(8'($urandom));
            end
        end
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("err_count", err_seen, m_err);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
